// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, bit-period
// derivation and the parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5,
        StMark   = 3'd6
    } uart_state_e;

    function automatic int unsigned bit_cycles(input int unsigned clock_rate,
                                               input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-producer / transmitter handshake bundle. tx_break exists only when
// UART_TX_BREAK_EN is defined.
interface uart_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx;
`ifdef UART_TX_BREAK_EN
    logic       tx_break;
`endif

    modport master (
        input  tx_ready, tx_done, tx,
`ifdef UART_TX_BREAK_EN
        output tx_break,
`endif
        output tx_valid, tx_data
    );

    modport slave (
        output tx_ready, tx_done, tx,
`ifdef UART_TX_BREAK_EN
        input  tx_break,
`endif
        input  tx_valid, tx_data
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while clr is low and pulses
// bit_end on the last cycle of each bit.
module uart_baud_tick #(
    parameter int unsigned BIT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);
    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign bit_end = !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1/8E1/8N2/8E2 UART transmitter, LSB first, registered TX line.
// Define UART_TX_BREAK_EN to add the tx_break input and break/mark generation.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned PARITY     = 1,
    parameter int unsigned STOP_BITS  = 1
) (
    input logic       clk,
    input logic       rst,
    uart_tx_if.slave  bus
);
    localparam int unsigned BIT_CYCLES = bit_cycles(CLOCK_RATE, BAUD_RATE);
    localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  sreg_q, sreg_d;
    logic [2:0]  bit_q, bit_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic        cnt_clr;

    // The bit timer only runs while a bit is actually being timed.
    assign cnt_clr = (state_q == StIdle) || (state_q == StBreak);

    uart_baud_tick #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .bit_end(bit_end)
    );

    assign bus.tx_ready = (state_q == StIdle);
    assign bus.tx_done  = done_q;
    assign bus.tx       = tx_q;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        bit_d    = bit_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (bus.tx_break) begin
                    state_d = StBreak;
                    tx_d    = 1'b0;
                end else
`endif
                if (bus.tx_valid) begin
                    state_d  = StStart;
                    tx_d     = 1'b0;
                    sreg_d   = bus.tx_data;
                    parity_d = even_parity(bus.tx_data);
                    bit_d    = 3'd0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = sreg_q[0];
                    sreg_d  = {1'b0, sreg_q[7:1]};
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY != 0) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_d   = sreg_q[0];
                        sreg_d = {1'b0, sreg_q[7:1]};
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    bit_d   = 3'd0;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                tx_d = 1'b0;
                if (!bus.tx_break) begin
                    state_d = StMark;
                    tx_d    = 1'b1;
                    bit_d   = 3'd0;
                end
            end
            StMark: begin
                // Mark-after-break lasts as long as the stop bits, no done pulse.
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = StIdle;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                bit_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            sreg_q   <= 8'h00;
            bit_q    <= 3'd0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            bit_q    <= bit_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BIT_CYCLES=16: one 8E1 instance and one 8N2
// instance, selected through a shared stimulus/observation mux.
module tb_uart_tx;
    localparam int unsigned CLOCK_RATE = 1600000;
    localparam int unsigned BAUD_RATE  = 100000;
    localparam int          FRAME_CYC  = 176;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       valid = 1'b0;
    logic       sel   = 1'b0;
    logic [7:0] data  = 8'h00;
`ifdef UART_TX_BREAK_EN
    logic       brk   = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    uart_tx_if if_a ();
    uart_tx_if if_b ();

    assign if_a.tx_valid = valid & ~sel;
    assign if_a.tx_data  = data;
    assign if_b.tx_valid = valid & sel;
    assign if_b.tx_data  = data;
`ifdef UART_TX_BREAK_EN
    assign if_a.tx_break = brk;
    assign if_b.tx_break = 1'b0;
`endif

    uart_tx #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .PARITY    (1),
        .STOP_BITS (1)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(if_a.slave)
    );

    uart_tx #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .PARITY    (0),
        .STOP_BITS (2)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(if_b.slave)
    );

    always #5 clk = ~clk;

    wire cur_tx    = sel ? if_b.tx       : if_a.tx;
    wire cur_ready = sel ? if_b.tx_ready : if_a.tx_ready;
    wire cur_done  = sel ? if_b.tx_done  : if_a.tx_done;

    always @(negedge clk) begin
        if (cur_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a byte from an idle line; returns right after the handshake edge.
    task automatic start_frame(input logic [7:0] d, input string tag);
        @(negedge clk);
        check_eq({tag, "_rdy_pre"}, 32'(cur_ready), 32'd1);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
    endtask

    // frame bit 0 is the first bit on the line; i counts negedges after the handshake.
    task automatic check_frame(input logic [10:0] frame, input string tag,
                               input logic nxt_valid, input logic [7:0] nxt_data);
        logic exp_tx;
        for (int i = 0; i <= FRAME_CYC; i++) begin
            @(negedge clk);
            exp_tx = (i < FRAME_CYC) ? frame[i / 16] : 1'b1;
            check_eq($sformatf("%s_tx@%0d", tag, i), 32'(cur_tx), 32'(exp_tx));
            check_eq($sformatf("%s_rdy@%0d", tag, i), 32'(cur_ready), 32'(i == FRAME_CYC));
            check_eq($sformatf("%s_done@%0d", tag, i), 32'(cur_done), 32'(i == FRAME_CYC));
            if (i == 0) begin
                valid = nxt_valid;
                data  = nxt_data;
            end
        end
    endtask

    initial begin
        int done_before;
        logic [10:0] f0f;

        // Reset with tx_valid asserted: must be ignored.
        valid = 1'b1;
        data  = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_a",   32'(if_a.tx),       32'd1);
        check_eq("rst_rdy_a",  32'(if_a.tx_ready), 32'd1);
        check_eq("rst_done_a", 32'(if_a.tx_done),  32'd0);
        check_eq("rst_tx_b",   32'(if_b.tx),       32'd1);
        check_eq("rst_rdy_b",  32'(if_b.tx_ready), 32'd1);
        check_eq("rst_done_b", 32'(if_b.tx_done),  32'd0);
        valid = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_tx_a", 32'(if_a.tx), 32'd1);

        // 8E1: 0x55 -> 0,1,0,1,0,1,0,1,0,p=0,1
        start_frame(8'h55, "e55");
        check_frame(11'b10010101010, "e55", 1'b0, 8'h00);

        // 8E1: 0x80 -> data 0000_0001 (LSB first), parity 1
        start_frame(8'h80, "e80");
        check_frame(11'b11100000000, "e80", 1'b0, 8'h00);

        // 8N2: 0xFF -> start then ten highs
        @(negedge clk);
        sel = 1'b1;
        start_frame(8'hFF, "nff");
        check_frame(11'b11111111110, "nff", 1'b0, 8'h00);
        @(negedge clk);
        sel = 1'b0;

        // Back-to-back with tx_valid held: 0xA3 then 0x3C
        @(posedge clk);
        done_before = done_cnt;
        start_frame(8'hA3, "bb1");
        check_frame(11'b10101000110, "bb1", 1'b1, 8'h3C);
        check_frame(11'b10001111000, "bb2", 1'b0, 8'h00);
        @(posedge clk);
        check_eq("bb_done_cnt", 32'(done_cnt - done_before), 32'd2);

        // Reset during data bit 3 of 0x0F, then a clean 0xC3 frame.
        f0f = 11'b10000011110;
        done_before = done_cnt;
        start_frame(8'h0F, "r0f");
        for (int i = 0; i <= 70; i++) begin
            @(negedge clk);
            check_eq($sformatf("r0f_tx@%0d", i), 32'(cur_tx), 32'(f0f[i / 16]));
            if (i == 0) valid = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_tx",   32'(cur_tx),    32'd1);
        check_eq("mid_rst_rdy",  32'(cur_ready), 32'd1);
        check_eq("mid_rst_done", 32'(cur_done),  32'd0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_tx@%0d", i),  32'(cur_tx),    32'd1);
            check_eq($sformatf("post_rst_rdy@%0d", i), 32'(cur_ready), 32'd1);
        end
        check_eq("mid_rst_no_done", 32'(done_cnt - done_before), 32'd0);
        start_frame(8'hC3, "ec3");
        check_frame(11'b10110000110, "ec3", 1'b0, 8'h00);

`ifdef UART_TX_BREAK_EN
        // 300-cycle break with a byte waiting; byte goes out only after the mark.
        @(negedge clk);
        brk   = 1'b1;
        valid = 1'b1;
        data  = 8'h3C;
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check_eq($sformatf("brk_tx@%0d", i),   32'(cur_tx),    32'd0);
            check_eq($sformatf("brk_rdy@%0d", i),  32'(cur_ready), 32'd0);
            check_eq($sformatf("brk_done@%0d", i), 32'(cur_done),  32'd0);
            if (i == 299) brk = 1'b0;
        end
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            check_eq($sformatf("mark_tx@%0d", i),   32'(cur_tx),    32'd1);
            check_eq($sformatf("mark_rdy@%0d", i),  32'(cur_ready), 32'(i == 16));
            check_eq($sformatf("mark_done@%0d", i), 32'(cur_done),  32'd0);
        end
        @(posedge clk);
        check_frame(11'b10001111000, "ab3c", 1'b0, 8'h00);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter, LSB first, one start bit, optional even parity, 1 or 2 stop bits.
- Pairs with the existing UART receiver at the same CLOCK_RATE/BAUD_RATE/PARITY settings.
- Sits between the fabric byte producer (valid/ready handshake) and the FPGA TX pin.
- Idle line is high.

Parameters:
- CLOCK_RATE, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. BIT_CYCLES = CLOCK_RATE / BAUD_RATE (integer floor); BIT_CYCLES >= 2 is required.
- PARITY, 1: 1 = append even parity bit (XOR of the 8 data bits); 0 = no parity bit.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- tx_valid  input  1  byte offered on tx_data.
- tx_data  input  8  byte to send; sampled only at the handshake.
- tx_ready  output  1  high while idle and able to accept a byte.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.
- tx  output  1  serial line, registered.
- tx_break  input  1  only present with UART_TX_BREAK_EN.

Behaviour:
- Single clock (clk). Reset is synchronous, active-low (rst == 0 at a rising edge resets).
- Reset values: tx=1, tx_ready=1, tx_done=0, state=IDLE, bit and cycle counters=0, shift register=0. tx_valid is ignored while rst=0.
- Frame length N = 1 + 8 + PARITY + STOP_BITS bits. Each bit lasts exactly BIT_CYCLES clocks.
- Handshake: a byte is accepted at edge k when tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register and the parity bit is computed at that edge.
  - tx_ready=0 from k+1.
  - Later changes on tx_data are ignored.
- Timing after acceptance:
  - tx goes low (start bit) at k+1.
  - Data bits follow d0..d7, then parity if PARITY=1, then the stop bits (high).
- At edge k+1+N*BIT_CYCLES: state returns to IDLE, tx_ready=1, and tx_done=1 for exactly one cycle. tx stays high.
- Back-to-back: with tx_valid held high, the next byte is accepted on the first cycle tx_ready=1. Frame-to-frame spacing is N*BIT_CYCLES+1 clocks, i.e. one extra high cycle, which reads as part of the stop bit.
- States:
  - IDLE -> START on handshake.
  - START -> DATA after BIT_CYCLES.
  - DATA repeats 8 times, with a 3-bit bit index that wraps 7 -> 0.
  - DATA -> PARITY (PARITY=1) or STOP.
  - PARITY -> STOP.
  - STOP repeats STOP_BITS times, then -> IDLE.
  - Illegal state -> IDLE with tx=1.
- Cycle counter: counts 0..BIT_CYCLES-1, is cleared on every bit transition and on handshake, and is never free-running.
- Reset mid-frame: at the next edge tx=1, state=IDLE, tx_ready=1, no tx_done pulse. The partial frame is abandoned.
- tx_valid=1 while tx_ready=0: no effect. The producer must hold the byte until the handshake.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: the tx_break input exists.
  - If tx_break=1 while IDLE, at the next edge tx=0 and tx_ready=0, held while tx_break=1.
  - On release, tx=1 for STOP_BITS*BIT_CYCLES clocks (mark after break), then tx_ready=1. No tx_done pulse.
  - tx_break asserted mid-frame is ignored until the frame completes.
  - If tx_break and tx_valid are both high in IDLE, break wins and no byte is accepted.
- Not defined: no tx_break port, no break logic. Behaviour is otherwise identical.

Decomposition:
- Shared include uart_defs: state encodings (IDLE, START, DATA, PARITY, STOP, BREAK, MARK), BIT_CYCLES derivation, parity function.
- One sub-module, uart_baud_tick:
  - Counts 0..BIT_CYCLES-1, with clear input.
  - Outputs a one-cycle bit_end pulse.

Test Plan (CLOCK_RATE=1600000, BAUD_RATE=100000, so BIT_CYCLES=16):
- PARITY=1, STOP_BITS=1, send 0x55 at edge k:
  - tx sequence is 0,1,0,1,0,1,0,1,0,0,1, each bit 16 cycles.
  - tx_done and tx_ready=1 at k+177.
- Send 0x80 with PARITY=1 -> data bits 0,0,0,0,0,0,0,1, parity=1.
- PARITY=0, STOP_BITS=2, send 0xFF -> start 0, then 10 highs. tx_done at k+177.
- tx_valid held high with 0xA3 then 0x3C:
  - Second handshake at k+177, second start bit at k+178.
  - Exactly 2 tx_done pulses.
- rst=0 during data bit 3 of 0x0F:
  - tx=1 and tx_ready=1 at the next edge, no tx_done.
  - A following 0xC3 frame is bit-exact.
- UART_TX_BREAK_EN: tx_break high for 300 cycles in IDLE:
  - tx=0 for 300 cycles, then high for 16.
  - tx_ready returns 16 cycles after release.
  - A tx_valid offered during the break is accepted only afterwards.
